// File: rtl/bus_slave_resp_pkg.sv
// Shared types and constants for the bus slave responder.
package bus_slave_resp_pkg;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned ERR_CNT_W   = 8;

  typedef logic [WORD_DATA_W-1:0] word_data_t;
  typedef logic [ERR_CNT_W-1:0]   err_cnt_t;

  typedef enum logic [1:0] {
    BUS_SLV_IDLE = 2'd0,
    BUS_SLV_REQ  = 2'd1,
    BUS_SLV_RESP = 2'd2
  } bus_slv_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic err_cnt_t err_cnt_sat_inc(input err_cnt_t c);
    return (c == '1) ? c : c + err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/bus_slave_wdog.sv
// Access watchdog: counts REQ cycles, flags expiry, keeps a saturating timeout tally.
module bus_slave_wdog
  import bus_slave_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     inc,
  input  logic     err_inc,
  output logic     expired,
  output err_cnt_t err_cnt
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_cnt_t         err_cnt_q, err_cnt_d;

  // Next-state for wait counter and error tally.
  always_comb begin
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (err_inc) begin
      err_cnt_d = err_cnt_sat_inc(err_cnt_q);
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/bus_slave_resp.sv
// Slave-side bus responder: qualifies cs_/as_, runs req/ack to the back end,
// returns a one-cycle rdy_ pulse with read data, or an error word on timeout.
module bus_slave_resp
  import bus_slave_resp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  output logic              loc_req,
  output logic              loc_we,
  output logic [ADDR_W-1:0] loc_addr,
  output logic [31:0]       loc_wdata,
  input  logic [31:0]       loc_rdata,
  input  logic              loc_ack,
  output logic              timeout_o,
  output logic [7:0]        err_cnt
);

  bus_slv_state_e    state_q, state_d;
  logic              loc_req_q, loc_req_d;
  logic              loc_we_q, loc_we_d;
  logic [ADDR_W-1:0] loc_addr_q, loc_addr_d;
  word_data_t        loc_wdata_q, loc_wdata_d;
  word_data_t        data_q, data_d;
  logic              to_flag_q, to_flag_d;
  logic              rdy_q, rdy_d;
  word_data_t        rd_data_q, rd_data_d;
  logic              timeout_q, timeout_d;

  logic              wd_clr, wd_inc, wd_err, wd_expired;
  err_cnt_t          wd_err_cnt;

  bus_slave_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .err_inc (wd_err),
    .expired (wd_expired),
    .err_cnt (wd_err_cnt)
  );

  // FSM next-state, back-end request and bus response computation.
  // rdy_/rd_data/timeout_o are registered from the RESP state, so they appear
  // the cycle after RESP, keeping every bus output a pure flop.
  always_comb begin
    state_d     = state_q;
    loc_req_d   = loc_req_q;
    loc_we_d    = loc_we_q;
    loc_addr_d  = loc_addr_q;
    loc_wdata_d = loc_wdata_q;
    data_d      = data_q;
    to_flag_d   = to_flag_q;
    rdy_d       = DISABLE_;
    rd_data_d   = '0;
    timeout_d   = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    wd_err      = 1'b0;
    unique case (state_q)
      BUS_SLV_IDLE: begin
        if (cs_ == ENABLE_ && as_ == ENABLE_) begin
          loc_addr_d  = s_addr;
          loc_wdata_d = wr_data;
          loc_we_d    = (rw == WRITE);
          loc_req_d   = 1'b1;
          wd_clr      = 1'b1;
          state_d     = BUS_SLV_REQ;
        end
      end
      BUS_SLV_REQ: begin
        if (cs_ == DISABLE_ || as_ == DISABLE_) begin
          loc_req_d = 1'b0;
          state_d   = BUS_SLV_IDLE;
        end else if (loc_ack) begin
          loc_req_d = 1'b0;
          if (!loc_we_q) data_d = loc_rdata;
          to_flag_d = 1'b0;
          state_d   = BUS_SLV_RESP;
        end else if (wd_expired) begin
          loc_req_d = 1'b0;
          if (!loc_we_q) data_d = ERR_DATA;
          to_flag_d = 1'b1;
          wd_err    = 1'b1;
          state_d   = BUS_SLV_RESP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      BUS_SLV_RESP: begin
        rdy_d     = ENABLE_;
        rd_data_d = loc_we_q ? '0 : data_q;
        timeout_d = to_flag_q;
        state_d   = BUS_SLV_IDLE;
      end
      default: begin
        state_d = BUS_SLV_IDLE;
      end
    endcase
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= BUS_SLV_IDLE;
      loc_req_q   <= 1'b0;
      loc_we_q    <= 1'b0;
      loc_addr_q  <= '0;
      loc_wdata_q <= '0;
      data_q      <= '0;
      to_flag_q   <= 1'b0;
      rdy_q       <= DISABLE_;
      rd_data_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      loc_req_q   <= loc_req_d;
      loc_we_q    <= loc_we_d;
      loc_addr_q  <= loc_addr_d;
      loc_wdata_q <= loc_wdata_d;
      data_q      <= data_d;
      to_flag_q   <= to_flag_d;
      rdy_q       <= rdy_d;
      rd_data_q   <= rd_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rdy_      = rdy_q;
  assign rd_data   = rd_data_q;
  assign loc_req   = loc_req_q;
  assign loc_we    = loc_we_q;
  assign loc_addr  = loc_addr_q;
  assign loc_wdata = loc_wdata_q;
  assign timeout_o = timeout_q;
  assign err_cnt   = wd_err_cnt;

endmodule

// File: tb/tb_bus_slave_resp.sv
// Self-checking bench for bus_slave_resp: directed table, directed corner
// sequences and randomized accesses against a behavioural model.
module tb_bus_slave_resp;

  localparam int          TMO  = 16;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset, cs_, as_, rw, loc_ack;
  logic [7:0]  s_addr, loc_addr, err_cnt;
  logic [31:0] wr_data, rd_data, loc_wdata, loc_rdata;
  logic        rdy_, loc_req, loc_we, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;
  int err_model = 0;

  always #5 clk = ~clk;

  bus_slave_resp #(
    .ADDR_W   (8),
    .TIMEOUT  (TMO),
    .ERR_DATA (ERRW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_       (cs_),
    .as_       (as_),
    .rw        (rw),
    .s_addr    (s_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rdy_      (rdy_),
    .loc_req   (loc_req),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .loc_ack   (loc_ack),
    .timeout_o (timeout_o),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic        exp_to;
    int          exp_req;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural expectation: ack on REQ cycle k (k < TMO) completes normally,
  // otherwise the watchdog ends the access after TMO REQ cycles.
  task automatic model(input logic r, input int ack_dly, input logic [31:0] rdat,
                       output logic [31:0] exp_rd, output logic exp_to, output int exp_req);
    bit acked;
    acked   = (ack_dly < TMO);
    exp_req = acked ? ack_dly + 1 : TMO;
    exp_to  = !acked;
    exp_rd  = r ? (acked ? rdat : ERRW) : 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, rdy_, 1);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_loc_req"}, loc_req, 0);
    check({tag, "_loc_we"}, loc_we, 0);
    check({tag, "_loc_addr"}, loc_addr, 0);
    check({tag, "_loc_wdata"}, loc_wdata, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Full access: ack asserted on REQ cycle ack_dly (never if >= TMO).
  task automatic do_access(input logic r, input logic [7:0] a, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rdat,
                           input logic [31:0] exp_rd, input logic exp_to, input int exp_req);
    int hi;
    bit early;
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = r; s_addr = a; wr_data = wd;
    loc_ack = 1'b0; loc_rdata = rdat;
    @(posedge clk); #1;
    check("req_start", loc_req, 1);
    check("loc_we", loc_we, !r);
    check("loc_addr", loc_addr, a);
    check("loc_wdata", loc_wdata, wd);
    hi = 1;
    early = 1'b0;
    for (int k = 0; k < 300 && loc_req; k++) begin
      @(negedge clk);
      loc_ack = (k == ack_dly);
      @(posedge clk); #1;
      if (rdy_ !== 1'b1) early = 1'b1;
      if (loc_req) hi++;
    end
    @(negedge clk);
    loc_ack = 1'b0;
    check("req_cycles", hi, exp_req);
    check("rdy_quiet", early, 0);
    if (exp_to && err_model < 255) err_model++;
    @(posedge clk); #1;
    check("rdy_pulse", rdy_, 0);
    check("rd_data", rd_data, exp_rd);
    check("timeout_o", timeout_o, exp_to);
    check("err_cnt", err_cnt, err_model);
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
    @(posedge clk); #1;
    check("rdy_end", rdy_, 1);
    check("rd_data_end", rd_data, 0);
    check("timeout_end", timeout_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    logic [31:0] e_rd;
    logic        e_to;
    int          e_req;
    bit          bad;

    vecs[0] = '{1'b1, 8'h10, 32'h0,         0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1};
    vecs[1] = '{1'b0, 8'h22, 32'hA5A5_0F0F, 5,  32'hFFFF_FFFF, 32'h0,         1'b0, 6};
    vecs[2] = '{1'b1, 8'h33, 32'h0,         99, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 16};
    vecs[3] = '{1'b1, 8'h44, 32'h0,         15, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 16};
    vecs[4] = '{1'b0, 8'hFF, 32'h0BAD_0BAD, 99, 32'h0,         32'h0,         1'b1, 16};
    vecs[5] = '{1'b1, 8'h00, 32'h0,         14, 32'h0,         32'h0,         1'b0, 15};
    vecs[6] = '{1'b0, 8'h80, 32'h0,         0,  32'h7777_7777, 32'h0,         1'b0, 1};

    reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; s_addr = '0;
    wr_data = '0; loc_rdata = '0; loc_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", rdy_, 1);

    // Directed table
    foreach (vecs[i])
      do_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].ack_dly,
                vecs[i].rdata, vecs[i].exp_rd, vecs[i].exp_to, vecs[i].exp_req);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      logic        r;
      logic [7:0]  a;
      logic [31:0] wd, rd;
      int          dly;
      r   = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      dly = $urandom_range(0, TMO + 4);
      model(r, dly, rd, e_rd, e_to, e_req);
      do_access(r, a, wd, dly, rd, e_rd, e_to, e_req);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Timeout tally saturates at 8'hFF
    for (int n = 0; n < 256; n++)
      do_access(1'b1, 8'(n), 32'h0, 99, 32'h0, ERRW, 1'b1, TMO);
    check("err_sat", err_cnt, 8'hFF);

    // Reset in the middle of REQ
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; s_addr = 8'h5A; wr_data = 32'h1357_9BDF;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_req", loc_req, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    err_model = 0;
    @(negedge clk);
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rdy", rdy_, 1);

    // Abort: as_ rises two cycles into REQ
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; s_addr = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    as_ = 1'b1; cs_ = 1'b1;
    @(posedge clk); #1;
    check("abort_req", loc_req, 0);
    check("abort_rdy", rdy_, 1);
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy_ !== 1'b1 || loc_req !== 1'b0) bad = 1'b1;
    end
    check("abort_quiet", bad, 0);
    check("abort_err", err_cnt, 0);
    do_access(1'b1, 8'h56, 32'h0, 2, 32'h0F0F_1234, 32'h0F0F_1234, 1'b0, 3);

    // Other slave selected: must never start an access
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (loc_req !== 1'b0 || rdy_ !== 1'b1) bad = 1'b1;
    end
    check("cs_ignored", bad, 0);
    @(negedge clk);
    as_ = 1'b1;

    // Coincident ack and expiry after reset: ack wins
    do_access(1'b1, 8'h99, 32'h0, TMO - 1, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, TMO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
